// File: rtl/icache_assoc.sv
// Set-associative instruction cache with FIFO replacement, an in-order line
// refill engine and whole-cache flush; hits answer one cycle after acceptance.
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_BITS  = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int WOFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_LSB   = 2 + WOFF_BITS + IDX_BITS;
    localparam int TAG_BITS  = ADDR_BITS - TAG_LSB;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WOFF_BITS-1:0] LAST_WORD = WOFF_BITS'(LINE_WORDS - 1);
    localparam logic [WAY_BITS-1:0]  LAST_WAY  = WAY_BITS'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t state, state_next;

    logic                valid_q  [WAYS][SETS];
    logic [TAG_BITS-1:0] tag_q    [WAYS][SETS];
    logic [31:0]         data_q   [WAYS][SETS][LINE_WORDS];
    logic [WAY_BITS-1:0] fill_ptr [SETS];
    logic [31:0]         line_buf [LINE_WORDS];

    logic [31:2]          addr_q;
    logic [WOFF_BITS-1:0] k_q;
    logic [WAY_BITS-1:0]  victim_q;
    logic                 victim_from_ptr_q;
    logic                 flush_pend_q;

    logic [WOFF_BITS-1:0] req_woff, fill_woff;
    logic [IDX_BITS-1:0]  req_idx, fill_idx;
    logic [TAG_BITS-1:0]  req_tag, fill_tag;
    logic                 hit, free_found, accept;
    logic [WAY_BITS-1:0]  hit_way, free_way;
    logic                 unused_addr_bits;

    assign req_woff  = req_addr[2 +: WOFF_BITS];
    assign req_idx   = req_addr[2 + WOFF_BITS +: IDX_BITS];
    assign req_tag   = req_addr[TAG_LSB +: TAG_BITS];
    assign fill_woff = addr_q[2 +: WOFF_BITS];
    assign fill_idx  = addr_q[2 + WOFF_BITS +: IDX_BITS];
    assign fill_tag  = addr_q[TAG_LSB +: TAG_BITS];
    assign unused_addr_bits = ^req_addr[1:0];

    assign busy   = (state != IDLE);
    assign accept = rdy_in && req_valid && !busy && !flush;

    // Tag match and first free way for the incoming request's set.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[w][req_idx] && !free_found) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                if (accept && !hit)
                    state_next = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[31:2+WOFF_BITS], k_q, 2'b00};
                if (mem_valid && (k_q == LAST_WORD))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_next;
    end

    // Valid bits, replacement pointers and the response register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    valid_q[w][s] <= 1'b0;
            for (int s = 0; s < SETS; s++)
                fill_ptr[s] <= '0;
            flush_pend_q      <= 1'b0;
            resp_valid        <= 1'b0;
            resp_inst         <= '0;
            addr_q            <= '0;
            k_q               <= '0;
            victim_q          <= '0;
            victim_from_ptr_q <= 1'b0;
        end else if (rdy_in) begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++)
                            for (int s = 0; s < SETS; s++)
                                valid_q[w][s] <= 1'b0;
                    end else if (accept) begin
                        if (hit) begin
                            resp_valid <= 1'b1;
                            resp_inst  <= data_q[hit_way][req_idx][req_woff];
                        end else begin
                            addr_q            <= req_addr[31:2];
                            k_q               <= '0;
                            victim_q          <= free_found ? free_way : fill_ptr[req_idx];
                            victim_from_ptr_q <= !free_found;
                        end
                    end
                end
                REFILL: begin
                    if (flush)
                        flush_pend_q <= 1'b1;
                    if (mem_valid) begin
                        k_q <= k_q + 1'b1;
                        // The last word is still in flight, so bypass it straight to the response.
                        if (k_q == LAST_WORD) begin
                            resp_valid <= 1'b1;
                            resp_inst  <= (fill_woff == LAST_WORD) ? mem_data : line_buf[fill_woff];
                        end
                    end
                end
                DONE: begin
                    if (flush_pend_q || flush) begin
                        for (int w = 0; w < WAYS; w++)
                            for (int s = 0; s < SETS; s++)
                                valid_q[w][s] <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end else begin
                        valid_q[victim_q][fill_idx] <= 1'b1;
                    end
                    if (victim_from_ptr_q)
                        fill_ptr[fill_idx] <= (fill_ptr[fill_idx] == LAST_WAY) ? '0
                                                                               : fill_ptr[fill_idx] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line buffer and tag/data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if ((state == REFILL) && mem_valid)
                line_buf[k_q] <= mem_data;
            if (state == DONE) begin
                tag_q[victim_q][fill_idx] <= fill_tag;
                for (int w = 0; w < LINE_WORDS; w++)
                    data_q[victim_q][fill_idx][w] <= line_buf[w];
            end
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (2 ways, 4 sets, 4-word lines): directed
// requests push expected words/latencies and refill addresses; a monitor checks them.
module tb_icache_assoc;
    localparam int LW = 4;

    typedef struct {
        logic [31:0] inst;
        int          accept_edge;
        int          latency;
    } resp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, req_valid, flush, mem_valid;
    logic [31:0] req_addr, mem_data;
    logic        busy, resp_valid, mem_req;
    logic [31:0] resp_inst, mem_addr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    resp_t       resp_q[$];
    logic [31:0] maddr_q[$];
    resp_t       exp_r;
    logic [31:0] exp_a;

    icache_assoc #(.WAYS(2), .SETS(4), .LINE_WORDS(LW), .ADDR_BITS(17)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .flush     (flush),
        .busy      (busy),
        .resp_valid(resp_valid),
        .resp_inst (resp_inst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Backing store: line 0x1x0 -> 0xA0.., 0x2x0 -> 0xB0.., 0x3x0 -> 0xC0..
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        case (a[11:8])
            4'h1:    base = 32'h0000_00A0;
            4'h2:    base = 32'h0000_00B0;
            4'h3:    base = 32'h0000_00C0;
            default: base = 32'hDEAD_0000;
        endcase
        return base + 32'(a[3:2]);
    endfunction

    always_comb begin
        mem_valid = mem_req;
        mem_data  = mem_req ? mem_word(mem_addr) : 32'h0;
    end

    // Monitor: a response or word transfer only completes on an edge with rdy_in high.
    always @(negedge clk_in) begin
        if (rdy_in && resp_valid) begin
            if (resp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_resp: got inst 0x%08h at cycle %0d, expected none", resp_inst, cyc);
            end else begin
                exp_r = resp_q.pop_front();
                vectors++;
                if (resp_inst !== exp_r.inst) begin
                    miscompares++;
                    $display("[TB] FAIL resp_inst: got 0x%08h, expected 0x%08h", resp_inst, exp_r.inst);
                end
                vectors++;
                if ((cyc + 1 - exp_r.accept_edge) != exp_r.latency) begin
                    miscompares++;
                    $display("[TB] FAIL resp_latency: got %0d cycles, expected %0d (inst 0x%08h)",
                             cyc + 1 - exp_r.accept_edge, exp_r.latency, exp_r.inst);
                end
            end
        end
        if (rdy_in && mem_req && mem_valid) begin
            vectors++;
            if (maddr_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_mem_read: got mem_addr 0x%08h, expected no refill", mem_addr);
            end else begin
                exp_a = maddr_q.pop_front();
                if (mem_addr !== exp_a) begin
                    miscompares++;
                    $display("[TB] FAIL mem_addr: got 0x%08h, expected 0x%08h", mem_addr, exp_a);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One request for one edge; a miss also expects the four in-order word reads of its line.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] inst,
                                 input int latency, input bit miss);
        resp_t e;
        e.inst        = inst;
        e.accept_edge = cyc + 1;
        e.latency     = latency;
        resp_q.push_back(e);
        if (miss)
            for (int w = 0; w < LW; w++)
                maddr_q.push_back({addr[31:4], 4'h0} + 32'(w * 4));
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || resp_valid || resp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: got busy=%0b after %0d cycles, expected idle", busy, n);
        end
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by 100000 time units, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy",       {31'b0, busy},       32'h0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rst_mem_req",    {31'b0, mem_req},    32'h0);
        checkOutput("rst_mem_addr",   mem_addr,            32'h0);
        checkOutput("rst_resp_inst",  resp_inst,           32'h0);
        rst_in = 1'b0;
        tick();

        $display("[TB] cold miss then hit");
        applyStimulus(32'h104, 32'hA1, 5, 1'b1);
        wait_idle();
        applyStimulus(32'h10C, 32'hA3, 1, 1'b0);
        checkOutput("hit_mem_req", {31'b0, mem_req}, 32'h0);
        wait_idle();

        $display("[TB] back-to-back hits");
        applyStimulus(32'h100, 32'hA0, 1, 1'b0);
        applyStimulus(32'h104, 32'hA1, 1, 1'b0);
        applyStimulus(32'h108, 32'hA2, 1, 1'b0);
        applyStimulus(32'h10C, 32'hA3, 1, 1'b0);
        wait_idle();

        $display("[TB] FIFO replacement in set 0");
        applyStimulus(32'h200, 32'hB0, 5, 1'b1);
        wait_idle();
        applyStimulus(32'h300, 32'hC0, 5, 1'b1);
        wait_idle();
        applyStimulus(32'h204, 32'hB1, 1, 1'b0);
        wait_idle();
        applyStimulus(32'h100, 32'hA0, 5, 1'b1);
        wait_idle();
        applyStimulus(32'h304, 32'hC1, 1, 1'b0);
        wait_idle();
        applyStimulus(32'h208, 32'hB2, 5, 1'b1);
        wait_idle();
        applyStimulus(32'h104, 32'hA1, 1, 1'b0);
        wait_idle();

        $display("[TB] flush in idle");
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        checkOutput("flush_req_busy", {31'b0, busy},       32'h0);
        checkOutput("flush_req_resp", {31'b0, resp_valid}, 32'h0);
        applyStimulus(32'h104, 32'hA1, 5, 1'b1);
        wait_idle();

        $display("[TB] flush during refill");
        flush_idle();
        applyStimulus(32'h100, 32'hA0, 5, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        applyStimulus(32'h100, 32'hA0, 5, 1'b1);
        wait_idle();

        $display("[TB] stall during refill and response");
        flush_idle();
        applyStimulus(32'h104, 32'hA1, 10, 1'b1);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_mem_addr", mem_addr,          32'h104);
            checkOutput("stall_mem_req",  {31'b0, mem_req},  32'h1);
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 20 && !resp_valid; i++)
            tick();
        if (!resp_valid) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL stall_resp_timeout: got resp_valid=0, expected 1");
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stall_resp_valid", {31'b0, resp_valid}, 32'h1);
            checkOutput("stall_resp_inst",  resp_inst,           32'hA1);
        end
        rdy_in = 1'b1;
        wait_idle();

        $display("[TB] asynchronous reset mid-refill");
        applyStimulus(32'h304, 32'hC1, 5, 1'b1);
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        checkOutput("async_rst_mem_req", {31'b0, mem_req},    32'h0);
        checkOutput("async_rst_busy",    {31'b0, busy},       32'h0);
        checkOutput("async_rst_resp",    {31'b0, resp_valid}, 32'h0);
        #1;
        rst_in = 1'b0;
        resp_q.delete();
        maddr_q.delete();
        tick();
        applyStimulus(32'h104, 32'hA1, 5, 1'b1);
        wait_idle();

        tick();
        tick();
        checkOutput("resp_queue_drained",  32'(resp_q.size()),  32'h0);
        checkOutput("maddr_queue_drained", 32'(maddr_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with its own line-refill state machine. It sits between the instruction fetcher and the memory controller's instruction read port. It replaces the fixed direct-mapped cache plus external refill logic. It adds configurable ways, sets and line length, FIFO replacement, a whole-cache flush (fence.i), and a pipelined one-cycle hit path.

## Interface
- WAYS, 2: associativity, power of two, 1..8
- SETS, 16: sets per way, power of two, ≥2
- LINE_WORDS, 4: 32-bit words per line, power of two, ≥2
- ADDR_BITS, 17: significant address bits; higher bits ignored

- clk_in  in  1  clock; all sequential logic on posedge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low freezes all state and holds outputs
- req_valid  in  1  fetch request
- req_addr  in  32  byte address; bits [1:0] ignored
- flush  in  1  invalidate every line
- busy  out  1  refill in progress; requests not accepted
- resp_valid  out  1  resp_inst valid this cycle
- resp_inst  out  32  fetched instruction word
- mem_req  out  1  word read request to memory
- mem_addr  out  32  word-aligned byte address of requested word
- mem_valid  in  1  mem_data valid; completes current word read
- mem_data  in  32  returned word

## Operation
- Address split: woff = addr[2 +: log2(LINE_WORDS)]; index = next log2(SETS) bits; tag = remaining bits up to ADDR_BITS-1.
- State: valid bit and tag per (way, set), with per-set FIFO pointer fill_ptr[log2(WAYS)]. Data is not reset.
- States: IDLE, REFILL, DONE. busy = (state != IDLE).
- A request is accepted when rdy_in && req_valid && !busy && !flush.
- Hit: some way has a valid entry with a matching tag. The requested word is registered to resp_inst and resp_valid is set. No replacement-state change.
- Miss: latch addr and victim way; go to REFILL; word counter k = 0.
  - Victim is the lowest-numbered invalid way; if all are valid, fill_ptr[index].
- REFILL:
  - mem_req = 1 and mem_addr = {addr[31:2+log2 LW], k, 2'b00}.
  - On each edge with mem_valid, store mem_data in the line buffer word k and increment k.
  - The edge accepting word LINE_WORDS-1 moves to DONE.
  - Memory returns words in order, one per mem_valid.
- DONE (one cycle):
  - resp_valid = 1 and resp_inst = buffer word woff.
  - At the edge: write line, tag and valid to the victim way.
  - If the victim came from fill_ptr, increment fill_ptr[index] with wrap at WAYS.
  - Return to IDLE.
- Flush in IDLE: clear all valid bits at the edge; a simultaneous req is not accepted.
- Flush while busy: record it as pending. The refill completes and the response is still delivered, but the line is not installed. All valid bits are cleared at the DONE edge.
- rdy_in low: no state change; mem_valid and req are ignored; all outputs hold.
- Reset (asynchronous, effective immediately):
  - all valid bits 0, fill_ptr 0, state IDLE, pending flush 0;
  - busy, resp_valid, mem_req 0; resp_inst, mem_addr 0.
  - Mid-refill reset drops mem_req in the same cycle; the partial line is discarded.

## Timing
- Hit: accepted at edge N; resp_valid high during cycle N..N+1 only. One hit is accepted per cycle (fully pipelined).
- resp_valid is a one-cycle pulse per accepted request; responses come in request order.
- Miss accepted at edge N: mem_req rises after edge N with k = 0.
- mem_addr advances the cycle after each accepted mem_valid. mem_req stays high continuously until the last word's edge.
- Last word accepted at edge M: resp_valid during M..M+1; busy falls at M+1.
- Minimum miss penalty (mem_valid every cycle): response LINE_WORDS+1 cycles after acceptance.
- The line is visible to lookup for requests accepted at edge M+2 onward.

## Test plan
Parameters for all scenarios: WAYS=2, SETS=4, LINE_WORDS=4.

1. Cold miss then hit.
   - Stimulus: req 0x104; mem_valid every cycle with data 0xA0..0xA3.
   - Required: mem_addr 0x100, 0x104, 0x108, 0x10C; resp_inst 0xA1 5 cycles after acceptance.
   - Then req 0x10C: resp 0xA3 next cycle, mem_req stays 0.
2. FIFO replacement.
   - Stimulus: fill 0x100, 0x200, then 0x300 (all set 0).
   - Required: 0x300 evicts the 0x100 way; 0x200 hits; 0x100 misses and evicts the 0x200 way.
3. Flush.
   - Stimulus A: flush in IDLE. Required: req 0x104 misses.
   - Stimulus B: flush asserted during word 2 of a refill of 0x100. Required: response delivered; the next req 0x100 misses.
4. Stall.
   - Stimulus: rdy_in low for 3 cycles at k = 1 while mem_valid = 1.
   - Required: k, mem_addr 0x104 and resp held; refill completes with the correct word.
5. Async reset.
   - Stimulus: rst_in pulse between edges at k = 2.
   - Required: mem_req, busy 0 immediately; subsequent req 0x104 misses.
6. Back-to-back hits.
   - Stimulus: 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
   - Required: 4 consecutive resp_valid cycles with data 0xA0..0xA3.
